display_frame_integrator: RTL and testbench

Evaluator-side receiver for the garbled display circuit output. Each evaluation of the display circuit yields one WIDTH×HEIGHT pixel frame in which every lit segment appears only with a fixed probability, so no single frame reveals the message. This block accepts those frames row by row and keeps a saturating per-pixel hit count over a configurable window of frames. It then thresholds the counts and streams the reconstructed, stable bitmap to the display/scanout logic.

---
 rtl/display_pkg.sv | 14 +
 rtl/sat_row_update.sv | 31 +++
 rtl/display_frame_integrator.sv | 157 +++++++++++++++
 tb/tb_display_frame_integrator.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared display geometry, counter width and integrator state encoding.
// The display circuit generator uses the same WIDTH/HEIGHT defaults.
package display_pkg;

    localparam int DISP_WIDTH  = 120;
    localparam int DISP_HEIGHT = 52;
    localparam int DISP_CNT_W  = 4;

    typedef enum logic [0:0] {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } integ_state_e;

endpackage

// File: rtl/sat_row_update.sv
// One row of saturating per-pixel hit counters: increment step and threshold compare.
// Purely combinational; the top muxes the active row in and out.
module sat_row_update #(
    parameter int WIDTH = 120,
    parameter int CNT_W = 4
) (
    input  logic [WIDTH-1:0][CNT_W-1:0] cnt_row,
    input  logic [WIDTH-1:0]            inc,
    input  logic [CNT_W-1:0]            threshold,
    output logic [WIDTH-1:0][CNT_W-1:0] cnt_next,
    output logic [WIDTH-1:0]            ge
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Saturating increment and threshold compare per pixel
    always_comb begin
        cnt_next = cnt_row;
        ge       = '0;
        for (int x = 0; x < WIDTH; x++) begin
            if (inc[x] && (cnt_row[x] != CNT_MAX)) begin
                cnt_next[x] = cnt_row[x] + CNT_ONE;
            end else begin
                cnt_next[x] = cnt_row[x];
            end
            ge[x] = (cnt_row[x] >= threshold);
        end
    end

endmodule

// File: rtl/display_frame_integrator.sv
// Integrates probabilistic display frames into per-pixel hit counts over a window,
// then streams the thresholded bitmap out row by row.
module display_frame_integrator
    import display_pkg::*;
#(
    parameter int WIDTH  = DISP_WIDTH,
    parameter int HEIGHT = DISP_HEIGHT,
    parameter int CNT_W  = DISP_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cfg_nframes,
    input  logic [CNT_W-1:0] cfg_threshold,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_row,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_row,
    output logic             out_last,
    output logic             err_framing
);

    localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [RW-1:0]    LAST_ROW = RW'(HEIGHT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    integ_state_e state_r, state_s;
    logic [RW-1:0]    row_idx_r, emit_row_r, sel_s;
    logic [CNT_W-1:0] frame_cnt_r, nframes_r, threshold_r, nfr_cfg_s, nfr_eff_s;
    logic             err_framing_r;
    logic [WIDTH-1:0][CNT_W-1:0] cnt_r [HEIGHT];
    logic [WIDTH-1:0][CNT_W-1:0] cur_row_s, next_row_s;
    logic [WIDTH-1:0] ge_s;
    logic beat_s, emit_hs_s, win_start_s, row_is_last_s, frame_end_s, window_done_s, emit_done_s;

    assign in_ready    = (state_r == ACCUM);
    assign out_valid   = (state_r == EMIT);
    assign err_framing = err_framing_r;

    assign beat_s        = in_valid && in_ready;
    assign emit_hs_s     = out_valid && out_ready;
    assign win_start_s   = (frame_cnt_r == '0) && (row_idx_r == '0);
    assign row_is_last_s = (row_idx_r == LAST_ROW);
    assign frame_end_s   = beat_s && (in_last || row_is_last_s);
    assign nfr_cfg_s     = (cfg_nframes == '0) ? CNT_ONE : cfg_nframes;
    // The first beat of a window decides with the live config, which it is latching.
    assign nfr_eff_s     = win_start_s ? nfr_cfg_s : nframes_r;
    assign window_done_s = frame_end_s && ((frame_cnt_r + CNT_ONE) == nfr_eff_s);
    assign emit_done_s   = emit_hs_s && (emit_row_r == LAST_ROW);

    assign sel_s     = (state_r == EMIT) ? emit_row_r : row_idx_r;
    assign cur_row_s = cnt_r[sel_s];

    sat_row_update #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_row (
        .cnt_row   (cur_row_s),
        .inc       (in_row),
        .threshold (threshold_r),
        .cnt_next  (next_row_s),
        .ge        (ge_s)
    );

    // Outputs are gated so an idle bus shows zeros rather than stale compares.
    assign out_row  = out_valid ? ge_s : '0;
    assign out_last = out_valid && (emit_row_r == LAST_ROW);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ACCUM;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state decode; clear overrides every handshake
    always_comb begin
        state_s = state_r;
        if (clear) begin
            state_s = ACCUM;
        end else begin
            case (state_r)
                ACCUM:   state_s = window_done_s ? EMIT : ACCUM;
                EMIT:    state_s = emit_done_s ? ACCUM : EMIT;
                default: state_s = ACCUM;
            endcase
        end
    end

    // Row/frame indices, latched window config, emit pointer and sticky framing flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_idx_r     <= '0;
            emit_row_r    <= '0;
            frame_cnt_r   <= '0;
            nframes_r     <= CNT_ONE;
            threshold_r   <= '0;
            err_framing_r <= 1'b0;
        end else if (clear) begin
            row_idx_r     <= '0;
            emit_row_r    <= '0;
            frame_cnt_r   <= '0;
            err_framing_r <= 1'b0;
        end else begin
            if (beat_s) begin
                if (win_start_s) begin
                    nframes_r   <= nfr_cfg_s;
                    threshold_r <= cfg_threshold;
                end
                if (frame_end_s) begin
                    row_idx_r   <= '0;
                    frame_cnt_r <= frame_cnt_r + CNT_ONE;
                    if (in_last != row_is_last_s) begin
                        err_framing_r <= 1'b1;
                    end
                end else begin
                    row_idx_r <= row_idx_r + RW'(1);
                end
                if (window_done_s) begin
                    emit_row_r <= '0;
                end
            end
            if (emit_hs_s) begin
                if (emit_done_s) begin
                    emit_row_r  <= '0;
                    frame_cnt_r <= '0;
                end else begin
                    emit_row_r <= emit_row_r + RW'(1);
                end
            end
        end
    end

    // Counter array: accumulate on input beats, zero each row as it is emitted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < HEIGHT; r++) begin
                cnt_r[r] <= '0;
            end
        end else if (clear) begin
            for (int r = 0; r < HEIGHT; r++) begin
                cnt_r[r] <= '0;
            end
        end else begin
            for (int r = 0; r < HEIGHT; r++) begin
                if ((RW'(r) == sel_s) && beat_s) begin
                    cnt_r[r] <= next_row_s;
                end else if ((RW'(r) == sel_s) && emit_hs_s) begin
                    cnt_r[r] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_frame_integrator.sv
// Directed self-checking bench for display_frame_integrator (120x52, 4-bit counters).
module tb_display_frame_integrator;

    localparam int W = 120;
    localparam int H = 52;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [C-1:0] cfg_nframes = 4'd1;
    logic [C-1:0] cfg_threshold = 4'd1;
    logic         clear = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_row = '0;
    logic         in_last = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_row;
    logic         out_last;
    logic         err_framing;

    int checks = 0;
    int failures = 0;
    logic [W-1:0] exp_mem [H];

    display_frame_integrator #(.WIDTH(W), .HEIGHT(H), .CNT_W(C)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_nframes(cfg_nframes), .cfg_threshold(cfg_threshold),
        .clear(clear), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
        .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_last(out_last), .err_framing(err_framing)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // kind 0 empty, 1 one-hot bit r, 2 window test, 3 all ones, 4 bit 2r+1, 5 bit 60 on row 0, 6 pixel (2,7)
    function automatic logic [W-1:0] pat(input int kind, input int f, input int r);
        logic [W-1:0] v;
        v = '0;
        case (kind)
            1: v[r] = 1'b1;
            2: begin
                if (r == 0 && f < 9) v[0] = 1'b1;
                if (r == 1 && f < 8) v[5] = 1'b1;
            end
            3: v = '1;
            4: v[2*r+1] = 1'b1;
            5: if (r == 0) v[60] = 1'b1;
            6: if (r == 2) v[7] = 1'b1;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic send_frame(input int kind, input int f, input int nrows, input bit with_last);
        chk("in_ready_at_frame_start", in_ready, 1'b1);
        for (int r = 0; r < nrows; r++) begin
            in_valid = 1'b1;
            in_row   = pat(kind, f, r);
            in_last  = with_last && (r == nrows - 1);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_row   = '0;
    endtask

    task automatic fill_exp(input int kind);
        for (int r = 0; r < H; r++) exp_mem[r] = pat(kind, 0, r);
    endtask

    task automatic drain(input bit stall, input bit hold_in);
        int k;
        int cyc;
        bit hs;
        k = 0;
        cyc = 0;
        while (k < H && cyc < 2000) begin
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            if (hold_in) begin
                in_valid = 1'b1;
                in_row   = '1;
            end
            chk("out_valid_in_emit", out_valid, 1'b1);
            chk("in_ready_in_emit", in_ready, 1'b0);
            chk($sformatf("out_row_%0d", k), out_row, exp_mem[k]);
            chk($sformatf("out_last_%0d", k), out_last, (k == H - 1));
            hs = out_valid && out_ready;
            @(negedge clk);
            if (hs) k++;
            cyc++;
        end
        in_valid  = 1'b0;
        in_row    = '0;
        out_ready = 1'b0;
        chk("emit_rows_within_budget", k, H);
        chk("in_ready_after_emit", in_ready, 1'b1);
        chk("out_valid_after_emit", out_valid, 1'b0);
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("clear_in_ready", in_ready, 1'b1);
        chk("clear_out_valid", out_valid, 1'b0);
        chk("clear_err", err_framing, 1'b0);
        chk("clear_out_row", out_row, '0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_row", out_row, '0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_err", err_framing, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single frame, one-hot rows, pass-through at threshold 1
        cfg_nframes = 4'd1; cfg_threshold = 4'd1;
        send_frame(1, 0, H, 1'b1);
        chk("t1_out_valid_next_cycle", out_valid, 1'b1);
        chk("t1_in_ready_low", in_ready, 1'b0);
        fill_exp(1);
        drain(1'b0, 1'b0);

        // Ten-frame window, threshold 9; mid-window config changes ignored
        cfg_nframes = 4'd10; cfg_threshold = 4'd9;
        for (int f = 0; f < 10; f++) begin
            send_frame(2, f, H, 1'b1);
            if (f == 0) begin
                cfg_nframes = 4'd2; cfg_threshold = 4'd1;
            end
        end
        for (int r = 0; r < H; r++) exp_mem[r] = '0;
        exp_mem[0][0] = 1'b1;
        drain(1'b0, 1'b0);

        // Fifteen frames at threshold 15, then counters must have been zeroed
        cfg_nframes = 4'd15; cfg_threshold = 4'd15;
        for (int f = 0; f < 15; f++) send_frame(6, f, H, 1'b1);
        fill_exp(6);
        drain(1'b0, 1'b0);
        cfg_nframes = 4'd0; cfg_threshold = 4'd1;
        send_frame(0, 0, H, 1'b1);
        fill_exp(0);
        drain(1'b0, 1'b0);
        cfg_nframes = 4'd1; cfg_threshold = 4'd0;
        send_frame(0, 0, H, 1'b1);
        fill_exp(3);
        drain(1'b0, 1'b0);

        // Stalled output with input pressure; nothing may leak into the next window
        cfg_nframes = 4'd1; cfg_threshold = 4'd1;
        send_frame(4, 0, H, 1'b1);
        fill_exp(4);
        drain(1'b1, 1'b1);
        send_frame(0, 0, H, 1'b1);
        fill_exp(0);
        drain(1'b0, 1'b0);

        // Full-height frame without in_last flags framing error, sticky through emit
        send_frame(4, 0, H, 1'b0);
        chk("err_missing_last", err_framing, 1'b1);
        fill_exp(4);
        drain(1'b0, 1'b0);
        chk("err_sticky", err_framing, 1'b1);
        pulse_clear();

        // Short frame (in_last on row 3) still counts; next frame restarts at row 0
        cfg_nframes = 4'd2; cfg_threshold = 4'd1;
        send_frame(1, 0, 4, 1'b1);
        chk("err_short_frame", err_framing, 1'b1);
        chk("short_frame_stays_accum", in_ready, 1'b1);
        send_frame(5, 0, H, 1'b1);
        for (int r = 0; r < H; r++) exp_mem[r] = '0;
        for (int r = 0; r < 4; r++) exp_mem[r][r] = 1'b1;
        exp_mem[0][60] = 1'b1;
        drain(1'b0, 1'b0);

        // Clear mid-window discards partial accumulation
        cfg_nframes = 4'd3; cfg_threshold = 4'd1;
        send_frame(3, 0, H, 1'b1);
        pulse_clear();
        cfg_nframes = 4'd1;
        send_frame(4, 0, H, 1'b1);
        fill_exp(4);
        drain(1'b0, 1'b0);

        // Clear mid-emit, coincident with a handshake
        send_frame(3, 0, H, 1'b1);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        pulse_clear();
        out_ready = 1'b0;
        send_frame(0, 0, H, 1'b1);
        fill_exp(0);
        drain(1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
